// File: rtl/game_beam_gen.sv
// game_beam_gen: 640x480@60 VGA beam source for pacman_game.
// Generates raw timing, centred game-window coordinates and strobes, then
// re-aligns sync and blanking with the game's colour return path.
module game_beam_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned GAME_W      = 224,
  parameter int unsigned GAME_H      = 288,
  parameter int unsigned SCALE       = 1,
  parameter int unsigned RGB_LATENCY = 2
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  output logic [8:0] sx,
  output logic [8:0] sy,
  output logic       game_pix_stb,
  output logic       frame_stb,
  output logic       display_enabled,
  input  logic [3:0] R_in,
  input  logic [3:0] G_in,
  input  logic [3:0] B_in,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W     = $clog2(H_TOTAL);
  localparam int unsigned VC_W     = $clog2(V_TOTAL);
  localparam int unsigned C_W      = 9;
  localparam int unsigned SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned H_OFF    = (H_VISIBLE - GAME_W * SCALE) / 2;
  localparam int unsigned V_OFF    = (V_VISIBLE - GAME_H * SCALE) / 2;
  localparam int unsigned H_END    = H_OFF + GAME_W * SCALE;
  localparam int unsigned V_END    = V_OFF + GAME_H * SCALE;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DLY      = 1 + RGB_LATENCY;

  // Reject window geometries that do not fit the visible area
  if (GAME_H * SCALE > V_VISIBLE) begin : g_bad_height
    $error("game_beam_gen: GAME_H*SCALE exceeds V_VISIBLE");
  end
  if (GAME_W * SCALE > H_VISIBLE) begin : g_bad_width
    $error("game_beam_gen: GAME_W*SCALE exceeds H_VISIBLE");
  end

  logic [HC_W-1:0]  hc_q, hc_d;
  logic [VC_W-1:0]  vc_q, vc_d;
  logic [SUB_W-1:0] hs_q, hs_d;
  logic [SUB_W-1:0] vs_q, vs_d;
  logic [C_W-1:0]   gy_q, gy_d;
  logic [C_W-1:0]   sx_q, sx_d;
  logic [C_W-1:0]   sy_q, sy_d;
  logic             gps_q, gps_d;
  logic             fs_q, fs_d;
  logic             de_q, de_d;
  logic [2:0]       dly_q [DLY];
  logic             hsync_q, vsync_q;
  logic [3:0]       r_q, g_q, b_q;

  logic hc_last_c, vc_last_c, in_win_c, row_end_c;
  logic hsync_raw_c, vsync_raw_c;

  // Beam position decode, counter and coordinate next-state
  always_comb begin
    hc_last_c   = (hc_q == HC_W'(H_TOTAL - 1));
    vc_last_c   = (vc_q == VC_W'(V_TOTAL - 1));
    in_win_c    = (hc_q >= HC_W'(H_OFF)) && (hc_q < HC_W'(H_END)) &&
                  (vc_q >= VC_W'(V_OFF)) && (vc_q < VC_W'(V_END));
    row_end_c   = in_win_c && (hc_q == HC_W'(H_END - 1));
    hsync_raw_c = !((hc_q >= HC_W'(HS_START)) && (hc_q < HC_W'(HS_END)));
    vsync_raw_c = !((vc_q >= VC_W'(VS_START)) && (vc_q < VC_W'(VS_END)));

    hc_d = hc_last_c ? '0 : hc_q + HC_W'(1);
    vc_d = vc_q;
    if (hc_last_c) vc_d = vc_last_c ? '0 : vc_q + VC_W'(1);

    // Sub-pixel column counter idles at 0 outside the window
    hs_d = (in_win_c && (hs_q != SUB_W'(SCALE - 1))) ? hs_q + SUB_W'(1) : '0;

    // Game row advances at the last window column once per SCALE lines
    vs_d = vs_q;
    gy_d = gy_q;
    if (hc_last_c && vc_last_c) begin
      vs_d = '0;
      gy_d = '0;
    end else if (row_end_c) begin
      if (vs_q == SUB_W'(SCALE - 1)) begin
        vs_d = '0;
        gy_d = gy_q + C_W'(1);
      end else begin
        vs_d = vs_q + SUB_W'(1);
      end
    end

    // sx_q holds the previous in-window column, so it is the running game x
    sx_d = '0;
    if (in_win_c && (hc_q != HC_W'(H_OFF))) sx_d = (hs_q == '0) ? sx_q + C_W'(1) : sx_q;
    sy_d  = in_win_c ? gy_q : '0;
    gps_d = in_win_c && (hs_q == '0);
    fs_d  = (hc_q == HC_W'(H_OFF)) && (vc_q == VC_W'(V_OFF));
    de_d  = in_win_c;
  end

  // Counters and registered game-side outputs
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hc_q  <= '0;
      vc_q  <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
      gy_q  <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      gps_q <= 1'b0;
      fs_q  <= 1'b0;
      de_q  <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      gy_q  <= gy_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      gps_q <= gps_d;
      fs_q  <= fs_d;
      de_q  <= de_d;
    end
  end

  // Delay {hsync, vsync, in_win} to line up with the returned colour
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DLY); i++) dly_q[i] <= 3'b110;
    end else begin
      dly_q[0] <= {hsync_raw_c, vsync_raw_c, in_win_c};
      for (int i = 1; i < int'(DLY); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // VGA pin register: blank colour outside the delayed window
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hsync_q <= dly_q[DLY-1][2];
      vsync_q <= dly_q[DLY-1][1];
      r_q     <= dly_q[DLY-1][0] ? R_in : 4'h0;
      g_q     <= dly_q[DLY-1][0] ? G_in : 4'h0;
      b_q     <= dly_q[DLY-1][0] ? B_in : 4'h0;
    end
  end

  assign sx              = sx_q;
  assign sy              = sy_q;
  assign game_pix_stb    = gps_q;
  assign frame_stb       = fs_q;
  assign display_enabled = de_q;
  assign vga_hsync       = hsync_q;
  assign vga_vsync       = vsync_q;
  assign vga_r           = r_q;
  assign vga_g           = g_q;
  assign vga_b           = b_q;

endmodule
